// File: rtl/mbist_mem_pkg.sv
// Shared types and constants for the MBIST memory bank wrapper.
package mbist_mem_pkg;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 3;
    localparam int NUM_BANK_MAX = 8;

    // Wide enough to hold RD_LAT_MAX-1, the largest value the read counter is loaded with.
    localparam int LAT_CNT_WD = $clog2(RD_LAT_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } bist_state_e;

endpackage

// File: rtl/mbist_mem_bank_wrapper.sv
// Wishbone slave fronting NUM_BANK single-port SRAM banks: one access at a time,
// with a fixed read latency and an error response for non-existent banks.
module mbist_mem_bank_wrapper
    import mbist_mem_pkg::*;
#(
    parameter  int BIST_ADDR_WD = 10,
    parameter  int BIST_DATA_WD = 32,
    parameter  int NUM_BANK     = 2,
    parameter  int RD_LAT       = 1,
    localparam int BANK_WD      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
    localparam int SEL_WD       = BIST_DATA_WD / 8
) (
    input  logic                             wb_clk_i,
    input  logic                             rst_n,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [BANK_WD+BIST_ADDR_WD-1:0]  wb_adr_i,
    input  logic [BIST_DATA_WD-1:0]          wb_dat_i,
    input  logic [SEL_WD-1:0]                wb_sel_i,
    output logic [BIST_DATA_WD-1:0]          wb_dat_o,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             func_clk_a,
    output logic                             func_clk_b,
    output logic [NUM_BANK-1:0]              func_cen_a,
    output logic [BIST_ADDR_WD-1:0]          func_addr_a,
    input  logic [NUM_BANK*BIST_DATA_WD-1:0] func_dout_a,
    output logic [NUM_BANK-1:0]              func_cen_b,
    output logic                             func_web_b,
    output logic [SEL_WD-1:0]                func_mask_b,
    output logic [BIST_ADDR_WD-1:0]          func_addr_b,
    output logic [BIST_DATA_WD-1:0]          func_din_b
);

    logic [BANK_WD-1:0]      adr_bank;
    logic [BIST_ADDR_WD-1:0] adr_word;
    logic                    accept;
    logic                    bank_ok;
    logic                    wr_strobe;
    logic                    rd_strobe;
    logic [NUM_BANK-1:0]     bank_hot;
    bist_state_e             state;
    logic [LAT_CNT_WD-1:0]   lat_cnt;
    logic [BANK_WD-1:0]      bank_q;
    logic [BIST_ADDR_WD-1:0] addr_q;
    logic [BIST_DATA_WD-1:0] rd_mux;

    assign adr_bank = wb_adr_i[BANK_WD+BIST_ADDR_WD-1:BIST_ADDR_WD];
    assign adr_word = wb_adr_i[BIST_ADDR_WD-1:0];
    assign bank_ok  = 32'(adr_bank) < NUM_BANK;
    assign bank_hot = NUM_BANK'(1) << adr_bank;

    // Gating with rst_n keeps every SRAM strobe quiet while reset is held, even with a live request.
    assign accept    = rst_n && (state == IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_strobe = accept && bank_ok && wb_we_i && (wb_sel_i != '0);
    assign rd_strobe = accept && bank_ok && !wb_we_i;

    assign func_clk_a  = wb_clk_i;
    assign func_clk_b  = wb_clk_i;
    assign func_cen_a  = ~(rd_strobe ? bank_hot : '0);
    assign func_cen_b  = ~(wr_strobe ? bank_hot : '0);
    assign func_web_b  = ~wr_strobe;
    assign func_mask_b = wb_sel_i;
    assign func_din_b  = wb_dat_i;

    // Live address while idle so the acceptance cycle sees it; held copy while a read is in flight.
    assign func_addr_a = (state == IDLE) ? adr_word : addr_q;
    assign func_addr_b = (state == IDLE) ? adr_word : addr_q;

    // NOTE: always_comb assigns a default before any conditional write, so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_BANK; k++) begin
            if (bank_q == BANK_WD'(k)) begin
                rd_mux = func_dout_a[k*BIST_DATA_WD +: BIST_DATA_WD];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bank_q <= adr_bank;
                        addr_q <= adr_word;
                        if (!bank_ok) begin
                            wb_err_o <= 1'b1;
                            state    <= RESP;
                        end else if (wb_we_i) begin
                            wb_ack_o <= 1'b1;
                            state    <= RESP;
                        end else begin
                            lat_cnt <= LAT_CNT_WD'(RD_LAT - 1);
                            state   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Master abandoning the cycle wins over a capture landing the same edge.
                    if (!wb_cyc_i) begin
                        lat_cnt <= '0;
                        state   <= IDLE;
                    end else if (lat_cnt == '0) begin
                        wb_dat_o <= rd_mux;
                        wb_ack_o <= 1'b1;
                        state    <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_mem_bank_wrapper.sv
// Directed bench: three wrapper configurations, each backed by a behavioural SRAM
// bank model with the matching read latency.
module tb_mbist_mem_bank_wrapper;

    logic clk = 1'b0;
    logic rst_n;

    // Instance 0: NUM_BANK=2 RD_LAT=1, instance 1: NUM_BANK=2 RD_LAT=3, instance 2: NUM_BANK=3 RD_LAT=2.
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [11:0] adr   [3];
    logic [31:0] dat_i [3];
    logic [3:0]  sel   [3];

    wire  [31:0] dat_o    [3];
    wire         ack      [3];
    wire         err      [3];
    wire  [7:0]  cen_a_w  [3];
    wire  [7:0]  cen_b_w  [3];
    wire         web_w    [3];
    wire  [9:0]  addr_b_w [3];
    wire  [31:0] din_w    [3];
    wire  [3:0]  mask_w   [3];

    int n_checks = 0;
    int n_fail   = 0;

    int          r_ack_at, r_err_at, r_n_ack, r_n_err, r_extra_cen;
    logic [7:0]  r_cena0, r_cenb0;
    logic        r_web0;
    logic [9:0]  r_addrb0;
    logic [31:0] r_din0;
    logic [3:0]  r_mask0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NB  = (g == 2) ? 3 : 2;
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

        logic [NB-1:0]    cen_a, cen_b;
        logic [NB*32-1:0] dout;
        logic             clk_a, clk_b;
        logic [9:0]       addr_a;
        logic [31:0]      mem  [NB][1024];
        logic [31:0]      pipe [NB][LAT];

        mbist_mem_bank_wrapper #(
            .BIST_ADDR_WD (10),
            .BIST_DATA_WD (32),
            .NUM_BANK     (NB),
            .RD_LAT       (LAT)
        ) u_dut (
            .wb_clk_i    (clk),
            .rst_n       (rst_n),
            .wb_cyc_i    (cyc[g]),
            .wb_stb_i    (stb[g]),
            .wb_we_i     (we[g]),
            .wb_adr_i    (adr[g][BW+9:0]),
            .wb_dat_i    (dat_i[g]),
            .wb_sel_i    (sel[g]),
            .wb_dat_o    (dat_o[g]),
            .wb_ack_o    (ack[g]),
            .wb_err_o    (err[g]),
            .func_clk_a  (clk_a),
            .func_clk_b  (clk_b),
            .func_cen_a  (cen_a),
            .func_addr_a (addr_a),
            .func_dout_a (dout),
            .func_cen_b  (cen_b),
            .func_web_b  (web_w[g]),
            .func_mask_b (mask_w[g]),
            .func_addr_b (addr_b_w[g]),
            .func_din_b  (din_w[g])
        );

        assign cen_a_w[g] = {{(8-NB){1'b1}}, cen_a};
        assign cen_b_w[g] = {{(8-NB){1'b1}}, cen_b};

        // Bank k, word a powers up holding 0xC0DE_0000 | k<<12 | a.
        initial begin
            for (int k = 0; k < NB; k++) begin
                for (int a = 0; a < 1024; a++) mem[k][a] = 32'hC0DE_0000 | (32'(k) << 12) | 32'(a);
                for (int i = 0; i < LAT; i++) pipe[k][i] = 32'hDEAD_BEEF;
            end
        end

        always @(posedge clk_b) begin
            for (int k = 0; k < NB; k++) begin
                if (!cen_b[k] && !web_w[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mask_w[g][b]) mem[k][addr_b_w[g]][b*8 +: 8] <= din_w[g][b*8 +: 8];
                    end
                end
            end
        end

        // Read data appears LAT cycles after the enable edge; junk fills the pipe otherwise.
        always @(posedge clk_a) begin
            for (int k = 0; k < NB; k++) begin
                pipe[k][0] <= !cen_a[k] ? mem[k][addr_a] : 32'hDEAD_BEEF;
                for (int i = 1; i < LAT; i++) pipe[k][i] <= pipe[k][i-1];
            end
        end

        for (genvar k = 0; k < NB; k++) begin : g_bank
            assign dout[k*32 +: 32] = pipe[k][LAT-1];
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ((ack[d] && err[d]) || ($countones(~{cen_a_w[d], cen_b_w[d]}) > 1)) begin
                    n_fail++;
                    $display("FAIL d%0d exclusive_outputs: ack=%b err=%b cen_a=%h cen_b=%h, required no ack+err and at most one cen low",
                             d, ack[d], err[d], cen_a_w[d], cen_b_w[d]);
                end
            end
        end
    end

    // Issues one request and records what happens over a fixed 10-cycle window.
    task automatic xfer(input int d, input logic w, input logic [1:0] bank, input logic [9:0] word,
                        input logic [31:0] data, input logic [3:0] be, input int drop_at);
        logic hit;
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = {bank, word}; dat_i[d] = data; sel[d] = be;
        r_ack_at = -1; r_err_at = -1; r_n_ack = 0; r_n_err = 0; r_extra_cen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == drop_at) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
            @(negedge clk);
            if (c == 0) begin
                r_cena0 = cen_a_w[d]; r_cenb0 = cen_b_w[d]; r_web0 = web_w[d];
                r_addrb0 = addr_b_w[d]; r_din0 = din_w[d]; r_mask0 = mask_w[d];
            end else if (cen_a_w[d] !== 8'hFF || cen_b_w[d] !== 8'hFF) begin
                r_extra_cen++;
            end
            hit = ack[d] || err[d];
            if (ack[d]) begin r_n_ack++; if (r_ack_at < 0) r_ack_at = c; end
            if (err[d]) begin r_n_err++; if (r_err_at < 0) r_err_at = c; end
            @(posedge clk); #1;
            if (hit) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++; if ({ack[d], err[d]} !== 2'b00) begin n_fail++; $display("FAIL d%0d reset_ack_err: got %b required 00", d, {ack[d], err[d]}); end
            n_checks++; if ({cen_a_w[d], cen_b_w[d]} !== 16'hFFFF) begin n_fail++; $display("FAIL d%0d reset_cen: got %h required ffff", d, {cen_a_w[d], cen_b_w[d]}); end
            n_checks++; if (web_w[d] !== 1'b1) begin n_fail++; $display("FAIL d%0d reset_web: got %b required 1", d, web_w[d]); end
            n_checks++; if (dat_o[d] !== 32'h0) begin n_fail++; $display("FAIL d%0d reset_dat_o: got %h required 0", d, dat_o[d]); end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write;
        xfer(0, 1'b1, 2'd1, 10'h3, 32'hA5A5_1234, 4'hF, -1);
        n_checks++; if (r_cenb0 !== 8'hFD) begin n_fail++; $display("FAIL wr_cen_b: got %h required fd", r_cenb0); end
        n_checks++; if (r_cena0 !== 8'hFF) begin n_fail++; $display("FAIL wr_cen_a: got %h required ff", r_cena0); end
        n_checks++; if (r_web0 !== 1'b0) begin n_fail++; $display("FAIL wr_web: got %b required 0", r_web0); end
        n_checks++; if (r_addrb0 !== 10'h3) begin n_fail++; $display("FAIL wr_addr_b: got %h required 003", r_addrb0); end
        n_checks++; if (r_din0 !== 32'hA5A5_1234) begin n_fail++; $display("FAIL wr_din: got %h required a5a51234", r_din0); end
        n_checks++; if (r_mask0 !== 4'hF) begin n_fail++; $display("FAIL wr_mask: got %h required f", r_mask0); end
        n_checks++; if (r_ack_at !== 1) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d required 1", r_ack_at); end
        n_checks++; if (r_n_ack !== 1 || r_n_err !== 0) begin n_fail++; $display("FAIL wr_ack_count: got ack=%0d err=%0d required 1/0", r_n_ack, r_n_err); end
        n_checks++; if (r_extra_cen !== 0) begin n_fail++; $display("FAIL wr_cen_one_cycle: got %0d extra required 0", r_extra_cen); end
    endtask

    task automatic test_read_lat1;
        xfer(0, 1'b0, 2'd1, 10'h3, 32'h0, 4'h0, -1);
        n_checks++; if (r_cena0 !== 8'hFD) begin n_fail++; $display("FAIL rd1_cen_a: got %h required fd", r_cena0); end
        n_checks++; if (r_cenb0 !== 8'hFF) begin n_fail++; $display("FAIL rd1_cen_b: got %h required ff", r_cenb0); end
        n_checks++; if (r_ack_at !== 2) begin n_fail++; $display("FAIL rd1_ack_cycle: got %0d required 2", r_ack_at); end
        n_checks++; if (r_n_ack !== 1) begin n_fail++; $display("FAIL rd1_ack_count: got %0d required 1", r_n_ack); end
        n_checks++; if (r_extra_cen !== 0) begin n_fail++; $display("FAIL rd1_cen_one_cycle: got %0d extra required 0", r_extra_cen); end
        n_checks++; if (dat_o[0] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL rd1_data: got %h required a5a51234", dat_o[0]); end
    endtask

    task automatic test_sel_zero;
        xfer(0, 1'b1, 2'd0, 10'h5, 32'h1111_2222, 4'h0, -1);
        n_checks++; if (r_cenb0 !== 8'hFF) begin n_fail++; $display("FAIL sel0_cen_b: got %h required ff", r_cenb0); end
        n_checks++; if (r_ack_at !== 1) begin n_fail++; $display("FAIL sel0_ack_cycle: got %0d required 1", r_ack_at); end
        xfer(0, 1'b0, 2'd0, 10'h5, 32'h0, 4'h0, -1);
        n_checks++; if (dat_o[0] !== 32'hC0DE_0005) begin n_fail++; $display("FAIL sel0_mem_untouched: got %h required c0de0005", dat_o[0]); end
    endtask

    task automatic test_byte_mask;
        xfer(0, 1'b1, 2'd0, 10'h7, 32'hAABB_CCDD, 4'b0101, -1);
        n_checks++; if (r_cenb0 !== 8'hFE) begin n_fail++; $display("FAIL mask_cen_b: got %h required fe", r_cenb0); end
        n_checks++; if (r_mask0 !== 4'b0101) begin n_fail++; $display("FAIL mask_value: got %b required 0101", r_mask0); end
        xfer(0, 1'b0, 2'd0, 10'h7, 32'h0, 4'h0, -1);
        n_checks++; if (dat_o[0] !== 32'hC0BB_00DD) begin n_fail++; $display("FAIL mask_readback: got %h required c0bb00dd", dat_o[0]); end
    endtask

    task automatic test_read_lat3;
        xfer(1, 1'b1, 2'd1, 10'h3, 32'hA5A5_1234, 4'hF, -1);
        n_checks++; if (r_ack_at !== 1) begin n_fail++; $display("FAIL rd3_wr_ack_cycle: got %0d required 1", r_ack_at); end
        xfer(1, 1'b0, 2'd1, 10'h3, 32'h0, 4'h0, -1);
        n_checks++; if (r_cena0 !== 8'hFD) begin n_fail++; $display("FAIL rd3_cen_a: got %h required fd", r_cena0); end
        n_checks++; if (r_extra_cen !== 0) begin n_fail++; $display("FAIL rd3_cen_one_cycle: got %0d extra required 0", r_extra_cen); end
        n_checks++; if (r_ack_at !== 4) begin n_fail++; $display("FAIL rd3_ack_cycle: got %0d required 4", r_ack_at); end
        n_checks++; if (r_n_ack !== 1) begin n_fail++; $display("FAIL rd3_ack_count: got %0d required 1", r_n_ack); end
        n_checks++; if (dat_o[1] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL rd3_data: got %h required a5a51234", dat_o[1]); end
        xfer(1, 1'b1, 2'd0, 10'h0, 32'h0000_0000, 4'hF, -1);
        n_checks++; if (dat_o[1] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL rd3_data_hold: got %h required a5a51234", dat_o[1]); end
    endtask

    task automatic test_bad_bank;
        xfer(2, 1'b0, 2'd2, 10'h1, 32'h0, 4'h0, -1);
        n_checks++; if (r_cena0 !== 8'hFB) begin n_fail++; $display("FAIL bank2_cen_a: got %h required fb", r_cena0); end
        n_checks++; if (r_ack_at !== 3) begin n_fail++; $display("FAIL bank2_ack_cycle: got %0d required 3", r_ack_at); end
        n_checks++; if (dat_o[2] !== 32'hC0DE_2001) begin n_fail++; $display("FAIL bank2_data: got %h required c0de2001", dat_o[2]); end
        xfer(2, 1'b1, 2'd3, 10'h4, 32'h0BAD_0BAD, 4'hF, -1);
        n_checks++; if (r_err_at !== 1) begin n_fail++; $display("FAIL badwr_err_cycle: got %0d required 1", r_err_at); end
        n_checks++; if (r_n_err !== 1 || r_n_ack !== 0) begin n_fail++; $display("FAIL badwr_counts: got err=%0d ack=%0d required 1/0", r_n_err, r_n_ack); end
        n_checks++; if ({r_cena0, r_cenb0} !== 16'hFFFF) begin n_fail++; $display("FAIL badwr_cen: got %h required ffff", {r_cena0, r_cenb0}); end
        n_checks++; if (r_extra_cen !== 0) begin n_fail++; $display("FAIL badwr_cen_later: got %0d required 0", r_extra_cen); end
        xfer(2, 1'b0, 2'd3, 10'h4, 32'h0, 4'h0, -1);
        n_checks++; if (r_err_at !== 1 || r_n_ack !== 0) begin n_fail++; $display("FAIL badrd_resp: got err_at=%0d ack=%0d required 1/0", r_err_at, r_n_ack); end
        n_checks++; if (r_cena0 !== 8'hFF) begin n_fail++; $display("FAIL badrd_cen_a: got %h required ff", r_cena0); end
        n_checks++; if (dat_o[2] !== 32'hC0DE_2001) begin n_fail++; $display("FAIL badrd_data_hold: got %h required c0de2001", dat_o[2]); end
    endtask

    task automatic test_abort;
        xfer(2, 1'b0, 2'd0, 10'h2, 32'h0, 4'h0, 1);
        n_checks++; if (r_cena0 !== 8'hFE) begin n_fail++; $display("FAIL abort_cen_a: got %h required fe", r_cena0); end
        n_checks++; if (r_n_ack !== 0 || r_n_err !== 0) begin n_fail++; $display("FAIL abort_no_resp: got ack=%0d err=%0d required 0/0", r_n_ack, r_n_err); end
        n_checks++; if (dat_o[2] !== 32'hC0DE_2001) begin n_fail++; $display("FAIL abort_data_hold: got %h required c0de2001", dat_o[2]); end
        xfer(2, 1'b1, 2'd1, 10'h9, 32'h1234_5678, 4'hF, -1);
        n_checks++; if (r_ack_at !== 1) begin n_fail++; $display("FAIL abort_next_wr_ack: got %0d required 1", r_ack_at); end
        n_checks++; if (r_cenb0 !== 8'hFD) begin n_fail++; $display("FAIL abort_next_wr_cen_b: got %h required fd", r_cenb0); end
        xfer(2, 1'b0, 2'd1, 10'h9, 32'h0, 4'h0, -1);
        n_checks++; if (r_ack_at !== 3 || dat_o[2] !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_readback: got ack_at=%0d data=%h required 3/12345678", r_ack_at, dat_o[2]); end
    endtask

    task automatic test_reset_mid_read;
        int late_resp;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = {2'd1, 10'h3}; sel[1] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({ack[1], err[1]} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ack_err: got %b required 00", {ack[1], err[1]}); end
        n_checks++; if ({cen_a_w[1], cen_b_w[1], web_w[1]} !== 17'h1FFFF) begin n_fail++; $display("FAIL rstmid_cen_web: got %h required 1ffff", {cen_a_w[1], cen_b_w[1], web_w[1]}); end
        n_checks++; if (dat_o[1] !== 32'h0) begin n_fail++; $display("FAIL rstmid_dat_o: got %h required 0", dat_o[1]); end
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        late_resp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack[1] || err[1]) late_resp++;
        end
        n_checks++; if (late_resp !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d responses required 0", late_resp); end
        xfer(1, 1'b0, 2'd1, 10'h3, 32'h0, 4'h0, -1);
        n_checks++; if (r_ack_at !== 4 || dat_o[1] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL rstmid_recover: got ack_at=%0d data=%h required 4/a5a51234", r_ack_at, dat_o[1]); end
    endtask

    initial begin
        rst_n = 1'b0;
        // A live write request is held during reset so any leak onto the SRAM strobes shows up.
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = 12'h0; dat_i[d] = 32'h0; sel[d] = 4'hF;
        end
        test_reset;
        test_write;
        test_read_lat1;
        test_sel_zero;
        test_byte_mask;
        test_read_lat3;
        test_bad_bank;
        test_abort;
        test_reset_mid_read;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_mem_bank_wrapper.md
MBIST_MEM_BANK_WRAPPER -- requirements
Module: mbist_mem_bank_wrapper

Interface
REQ-001 Parameter BIST_ADDR_WD, default 10, per-bank word address width.
REQ-002 Parameter BIST_DATA_WD, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter NUM_BANK, default 2, SRAM bank count, 1..8; BANK_WD = max(1, clog2(NUM_BANK)).
REQ-004 Parameter RD_LAT, default 1, SRAM read latency in cycles, 1..3.
REQ-005 Clock and reset: one clock, wb_clk_i; reset rst_n is asynchronous and active-low.
REQ-006 wb_clk_i  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write.
REQ-009 wb_adr_i  in  BANK_WD+BIST_ADDR_WD  bank index in the MSBs, word address in the LSBs.
REQ-010 wb_dat_i  in  BIST_DATA_WD  write data; wb_sel_i  in  BIST_DATA_WD/8  byte enables.
REQ-011 wb_dat_o  out  BIST_DATA_WD  registered read data; wb_ack_o, wb_err_o  out  1 each.
REQ-012 func_clk_a, func_clk_b  out  1 each  equal to wb_clk_i.
REQ-013 func_cen_a  out  NUM_BANK  per-bank read enable, active-low; func_addr_a  out  BIST_ADDR_WD  shared.
REQ-014 func_dout_a  in  NUM_BANK*BIST_DATA_WD  bank k occupies bits [k*BIST_DATA_WD +: BIST_DATA_WD].
REQ-015 func_cen_b  out  NUM_BANK  per-bank write enable, active-low; func_web_b  out  1  active-low.
REQ-016 func_mask_b, func_addr_b, func_din_b  out  shared byte mask, address and data.

Function
REQ-017 FSM states: IDLE, RD_WAIT, RESP.
REQ-018 IDLE accepts a request when wb_cyc_i & wb_stb_i are high; the bank index and word address SHALL be registered at acceptance.
REQ-019 When the bank index is >= NUM_BANK, the block SHALL NOT assert any cen and SHALL assert wb_err_o for one cycle in RESP.
REQ-020 Write: in the acceptance cycle, func_cen_b[bank]=0, func_web_b=0 and mask/addr/din = wb_sel_i/adr/dat_i; the FSM goes to RESP; wb_ack_o=1 on the next cycle.
REQ-021 A write with wb_sel_i==0 SHALL NOT assert func_cen_b and SHALL still be acked.
REQ-022 Read: in the acceptance cycle, func_cen_a[bank]=0 for exactly one cycle; the FSM goes to RD_WAIT with a latency counter loaded with RD_LAT-1.
REQ-023 RD_WAIT SHALL decrement the counter each cycle; at zero, it SHALL capture func_dout_a slice[bank] into wb_dat_o and go to RESP.
REQ-024 Read ack SHALL occur RD_LAT+1 cycles after acceptance; wb_dat_o SHALL hold its value until the next read capture.
REQ-025 RESP SHALL assert wb_ack_o or wb_err_o for exactly one cycle, then return to IDLE; no request is accepted in RESP.
REQ-026 wb_cyc_i low in RD_WAIT SHALL abort the read: return to IDLE, no ack, wb_dat_o unchanged.
REQ-027 wb_ack_o and wb_err_o SHALL never be high simultaneously; at most one cen bit of the read and write groups combined SHALL be low per cycle.
REQ-028 func_cen_a and func_cen_b SHALL be all-ones in every cycle other than an acceptance cycle.

Reset
REQ-029 With rst_n low: FSM=IDLE, counter=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, func_cen_a/b all-ones, func_web_b=1.
REQ-030 Reset asserted mid-read SHALL discard the transaction; no ack SHALL follow release.

Structure
REQ-031 Package mbist_mem_pkg SHALL hold the FSM state enum and the RD_LAT range constants.
REQ-032 Single module with no sub-module; the read-data bank mux is inline.

Verification
REQ-033 NUM_BANK=2, RD_LAT=1: write 0xA5A5_1234 to bank 1 addr 0x3, sel=0xF -> func_cen_b=2'b01 for one cycle; ack one cycle later.
REQ-034 Read bank 1 addr 0x3 with RD_LAT=3 -> func_cen_a=2'b01 for one cycle; ack 4 cycles after acceptance; wb_dat_o=0xA5A5_1234.
REQ-035 NUM_BANK=3, adr bank field=3 -> wb_err_o for one cycle; no cen low; no ack.
REQ-036 Write with sel=4'b0000 -> no cen_b low; ack is still returned.
REQ-037 Read with RD_LAT=2, wb_cyc_i dropped 1 cycle after acceptance -> no ack; FSM in IDLE; the next write is acked normally.
REQ-038 rst_n pulsed low during RD_WAIT -> all outputs at reset values; no ack after release.
